// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands, CHUNK bits per clock.
// Ports: clk, rst_n, in_valid/in_ready, a, b, cin, sub, out_valid/out_ready, sum, cout, ovf.
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic [KW-1:0]    k;

  logic [CHUNK-1:0] a_s;
  logic [CHUNK-1:0] b_s;
  logic [CHUNK-1:0] s;
  logic             c;
  logic             c_msb;
  logic             last;
  logic             accept;
  int               idx;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  assign idx  = int'(k) * CHUNK;
  assign a_s  = a_q[idx +: CHUNK];
  assign b_s  = b_q[idx +: CHUNK];
  assign last = (k == KLAST);

  assign {c, s} = {1'b0, a_s}
                + {1'b0, b_s}
                + {{CHUNK{1'b0}}, carry};

  // Carry into the slice MSB recovered from its sum bit;
  // for CHUNK=1 this reduces to the carry register.
  assign c_msb = a_s[CHUNK-1] ^ b_s[CHUNK-1] ^ s[CHUNK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)  state_nx = RUN;
      RUN:  if (last)      state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      k      <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      carry <= sub ? ~cin : cin;
      k     <= '0;
    end else if (state == RUN) begin
      sum_q[idx +: CHUNK] <= s;
      carry <= c;
      if (last) begin
        cout_q <= c;
        ovf_q  <= c_msb ^ c;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder at CHUNK = 8, 1 and 32.
// Table vectors plus a scoreboard queue of expected results.
module tb_chunked_serial_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    res_t        e;
  } vec_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [31:0] a_i = 0;
  logic [31:0] b_i = 0;
  logic        cin_i = 0;
  logic        sub_i = 0;
  logic [2:0]  iv = 0;
  logic [2:0]  ord = 0;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  cout;
  logic [2:0]  ovf;
  logic [31:0] sum [3];

  int nch [3] = '{4, 32, 1};
  int total = 0;
  int passed = 0;
  res_t q[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  chunked_serial_adder #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(in_ready[0]),
    .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i),
    .out_valid(out_valid[0]), .out_ready(ord[0]),
    .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0])
  );

  chunked_serial_adder #(.WIDTH(32), .CHUNK(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(in_ready[1]),
    .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i),
    .out_valid(out_valid[1]), .out_ready(ord[1]),
    .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1])
  );

  chunked_serial_adder #(.WIDTH(32), .CHUNK(32)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(in_ready[2]),
    .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i),
    .out_valid(out_valid[2]), .out_ready(ord[2]),
    .sum(sum[2]), .cout(cout[2]), .ovf(ovf[2])
  );

  task automatic chk(input string nm, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s dut%0d: got %h want %h", nm, d, act, exp);
  endtask

  function automatic res_t model(logic [31:0] a, logic [31:0] b,
                                 logic cin, logic sub);
    logic [32:0] full;
    logic [31:0] low;
    logic [31:0] be;
    logic        c0;
    res_t r;
    be = sub ? ~b : b;
    c0 = sub ? ~cin : cin;
    full = {1'b0, a} + {1'b0, be} + {32'd0, c0};
    low = {1'b0, a[30:0]} + {1'b0, be[30:0]} + {31'd0, c0};
    r.sum = full[31:0];
    r.cout = full[32];
    r.ovf = low[31] ^ full[32];
    return r;
  endfunction

  task automatic issue(input int d, input logic [31:0] a,
                       input logic [31:0] b, input logic cin,
                       input logic sub, input res_t e);
    @(negedge clk);
    a_i = a; b_i = b; cin_i = cin; sub_i = sub;
    iv[d] = 1;
    chk("in_ready_idle", d, 32'(in_ready[d]), 1);
    @(posedge clk);
    q.push_back(e);
    #1 iv[d] = 0;
  endtask

  task automatic collect(input int d, input string nm, input bit consume);
    int n;
    bit seen;
    res_t e;
    n = 0;
    seen = 0;
    while (!seen && n < nch[d] + 4) begin
      if (out_valid[d]) seen = 1;
      else begin
        @(posedge clk);
        #1 n++;
      end
    end
    e = q.pop_front();
    if (!seen) begin
      total++;
      $display("FAIL %s_timeout dut%0d: no out_valid in %0d cycles",
               nm, d, n);
      return;
    end
    chk({nm, "_lat"}, d, 32'(n), 32'(nch[d]));
    chk({nm, "_sum"}, d, sum[d], e.sum);
    chk({nm, "_cout"}, d, 32'(cout[d]), 32'(e.cout));
    chk({nm, "_ovf"}, d, 32'(ovf[d]), 32'(e.ovf));
    if (consume) begin
      ord[d] = 1;
      @(posedge clk);
      #1 ord[d] = 0;
      chk({nm, "_ov_drop"}, d, 32'(out_valid[d]), 0);
      chk({nm, "_ir_back"}, d, 32'(in_ready[d]), 1);
    end
  endtask

  task automatic op(input int d, input string nm, input logic [31:0] a,
                    input logic [31:0] b, input logic cin, input logic sub);
    issue(d, a, b, cin, sub, model(a, b, cin, sub));
    collect(d, nm, 1);
  endtask

  initial begin
    tbl[0] = '{32'hFFFFFFFF, 32'h1, 0, 0, '{32'h0, 1, 0}};
    tbl[1] = '{32'h7FFFFFFF, 32'h1, 0, 0, '{32'h80000000, 0, 1}};
    tbl[2] = '{32'h80000000, 32'h1, 0, 1, '{32'h7FFFFFFF, 1, 1}};
    tbl[3] = '{32'd5, 32'd7, 0, 1, '{32'hFFFFFFFE, 0, 0}};
    tbl[4] = '{32'd10, 32'd3, 1, 1, '{32'd6, 1, 0}};
    tbl[5] = '{32'h12345678, 32'h11111111, 0, 0, '{32'h23456789, 0, 0}};
    tbl[6] = '{32'd1, 32'd1, 1, 0, '{32'd3, 0, 0}};
    tbl[7] = '{32'd0, 32'd0, 0, 1, '{32'd0, 1, 0}};

    #2;
    for (int d = 0; d < 3; d++) begin
      chk("rst_sum", d, sum[d], 0);
      chk("rst_ov", d, 32'(out_valid[d]), 0);
      chk("rst_ir", d, 32'(in_ready[d]), 1);
    end
    #10 rst_n = 1;

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 8; i++) begin
        issue(d, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].e);
        collect(d, $sformatf("vec%0d", i), 1);
      end

      for (int i = 0; i < 6; i++)
        op(d, "rand", $urandom, $urandom, 1'($urandom), 1'($urandom));

      // asynchronous reset with a result held
      issue(d, 32'hFFFFFFFF, 32'h1, 0, 0, '{32'h0, 1, 0});
      collect(d, "prerst", 0);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("arst_sum", d, sum[d], 0);
      chk("arst_cout", d, 32'(cout[d]), 0);
      chk("arst_ovf", d, 32'(ovf[d]), 0);
      chk("arst_ov", d, 32'(out_valid[d]), 0);
      chk("arst_ir", d, 32'(in_ready[d]), 1);
      #1 rst_n = 1;

      // back-pressure with input churn
      begin
        res_t held;
        issue(d, 32'h0F0F0F0F, 32'h01010101, 0, 0,
              model(32'h0F0F0F0F, 32'h01010101, 0, 0));
        collect(d, "bp", 0);
        held = '{sum[d], cout[d], ovf[d]};
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          a_i = $urandom; b_i = $urandom;
          cin_i = 1'($urandom); sub_i = 1'($urandom);
          iv[d] = ~iv[d];
          @(posedge clk);
          #1;
          chk("bp_sum", d, sum[d], held.sum);
          chk("bp_cout", d, 32'(cout[d]), 32'(held.cout));
          chk("bp_ovf", d, 32'(ovf[d]), 32'(held.ovf));
          chk("bp_ov", d, 32'(out_valid[d]), 1);
          chk("bp_ir", d, 32'(in_ready[d]), 0);
        end
        @(negedge clk);
        a_i = 3; b_i = 4; cin_i = 0; sub_i = 0;
        iv[d] = 1;
        ord[d] = 1;
        @(posedge clk);
        #1 ord[d] = 0;
        chk("simul_ov", d, 32'(out_valid[d]), 0);
        chk("simul_ir", d, 32'(in_ready[d]), 1);
        @(posedge clk);
        q.push_back('{32'd7, 0, 0});
        #1 iv[d] = 0;
        chk("next_acc", d, 32'(in_ready[d]), 0);
        collect(d, "after_bp", 1);
      end

      // reset in the middle of an operation
      issue(d, 32'hDEADBEEF, 32'h1, 0, 0, '{32'h0, 0, 0});
      q.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 0;
      #3 rst_n = 1;
      begin
        bit bad;
        bad = 0;
        repeat (nch[d] + 3) begin
          @(posedge clk);
          #1 if (out_valid[d]) bad = 1;
        end
        chk("midrst_noout", d, 32'(bad), 0);
        chk("midrst_ir", d, 32'(in_ready[d]), 1);
      end
      issue(d, tbl[5].a, tbl[5].b, 0, 0, tbl[5].e);
      collect(d, "post_rst", 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/chunked_serial_adder.md
# chunked_serial_adder

Parametrised multi-cycle add/subtract unit that processes WIDTH-bit operands in CHUNK-bit slices, one slice per clock, with a registered carry between slices. It extends the 4-bit ripple-carry full-adder chain in three ways: generic width, area/timing trade-off via slice size, and subtract mode with signed-overflow detection. It sits between producer and consumer stages with a valid/ready handshake on both sides.

## Interface
- WIDTH, 32: operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 8: bits added per cycle. 1 ≤ CHUNK ≤ WIDTH. NCHUNK = WIDTH/CHUNK.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode are presented.
- in_ready  output  1  block accepts operands. Equals (state == IDLE).
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in in add mode; borrow-in in subtract mode.
- sub  input  1  0: A+B+cin; 1: A−B−cin.
- out_valid  output  1  result is valid. Equals (state == DONE).
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  raw carry out of the MSB. In subtract mode, 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- **Accept:** on an edge with in_valid && in_ready:
  - latch a, and b_eff = sub ? ~b : b.
  - carry register ← sub ? ~cin : cin.
  - chunk index k ← 0; state → RUN.
- **RUN:** each cycle computes slice k as {c, s} = a[k] + b_eff[k] + carry, using CHUNK-bit slices.
  - sum slice k ← s; carry ← c; k ← k+1.
  - On the last slice (k = NCHUNK−1):
    - cout ← c.
    - ovf ← carry into bit WIDTH−1 XOR c.
    - state → DONE.
- **DONE:** sum, cout and ovf are held. On an edge with out_ready, state → IDLE.
- **State transitions:** IDLE→RUN on accept; RUN→RUN while k < NCHUNK−1; RUN→DONE on the last slice; DONE→IDLE on out_ready. No other transitions.
- **Input qualification:** a, b, cin and sub are sampled only at acceptance. Changes on these inputs during RUN or DONE have no effect. in_valid is ignored outside IDLE.
- **Output hold:** sum, cout and ovf change only during RUN. They keep their last value otherwise, and are meaningful only while out_valid = 1.
- **Single-slice case:** CHUNK = WIDTH gives NCHUNK = 1, i.e. one RUN cycle.
- **CHUNK = 1:** the datapath becomes a bit-serial adder. The carry-into-MSB term for ovf is taken from the carry register in the final RUN cycle.

## Timing
- **Reset (rst_n low, asynchronous):**
  - state = IDLE, k = 0, carry = 0.
  - sum = 0, cout = 0, ovf = 0, out_valid = 0.
  - in_ready = 1.
- **Reset mid-operation:** any in-flight operation is discarded with no output produced. The block is in IDLE on the first edge after deassertion.
- **Latency:** with acceptance at edge T0, out_valid rises after edge T0+NCHUNK. It stays high until the edge at which out_ready = 1.
- **Back-pressure:** while out_valid = 1 and out_ready = 0, all outputs are stable and in_ready = 0.
- **Throughput:** at most one operation per NCHUNK+2 cycles. There is no overlap of operations. in_ready returns to 1 in the cycle after the result is consumed.
- **Simultaneous events:** in_valid asserted during DONE while out_ready = 1 is not accepted in that cycle. It is accepted on the next edge if still asserted.

## Test plan
- **Reset:** assert rst_n = 0 mid-clock → sum = 0, cout = 0, ovf = 0, out_valid = 0 and in_ready = 1 immediately, before any clock edge.
- **Add, carry-out** (WIDTH = 32, CHUNK = 8): 0xFFFFFFFF + 0x00000001, cin = 0 → sum = 0x00000000, cout = 1, ovf = 0. out_valid high exactly 4 cycles after the accept edge.
- **Signed overflow:**
  - add 0x7FFFFFFF + 0x00000001 → sum = 0x80000000, cout = 0, ovf = 1.
  - sub 0x80000000 − 0x00000001 → sum = 0x7FFFFFFF, cout = 1, ovf = 1.
- **Subtract with borrows:**
  - sub 5 − 7, cin = 0 → sum = 0xFFFFFFFE, cout = 0, ovf = 0.
  - sub 10 − 3, cin = 1 → sum = 6, cout = 1.
- **Back-pressure and input churn:** hold out_ready = 0 for 5 cycles after out_valid, toggling a, b and in_valid throughout → result stable, in_ready = 0, nothing new accepted. The next op is accepted only after out_ready = 1 plus one cycle.
- **Reset mid-RUN, then re-parametrise:**
  - pulse rst_n low after 2 slices → IDLE, no out_valid.
  - following op 0x12345678 + 0x11111111 → 0x23456789.
  - rerun the full suite with CHUNK = 1 and CHUNK = WIDTH; latency is 32 cycles and 1 cycle respectively.
